lsu_align: RTL and testbench
============================

# lsu_align

Load/store alignment unit between the execute stage and the data memory. It converts a byte address, access size and signedness into a word address, a 4-bit byte-enable mask and lane-shifted write data for the data memory. It splits misaligned halfword/word accesses that cross a word boundary into two consecutive memory accesses. On the load side it rebuilds the returned lanes into a right-justified, sign- or zero-extended 32-bit result.

## Interface
- ADDR_WIDTH, 11, word-address width of the data memory (DEPTH = 2**ADDR_WIDTH)
- DATA_WIDTH, 32, data width; fixed at 32, 4 byte lanes

- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  execute stage presents a memory op this cycle
- o_ready  out  1  op accepted this cycle (low during second half of a split)
- i_load  in  1  op is a load
- i_store  in  1  op is a store (wins if both set)
- i_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- i_unsigned  in  1  zero-extend load result (LBU/LHU)
- i_baddr  in  ADDR_WIDTH+2  byte address
- i_wdata  in  32  store data, right-justified
- o_addr  out  ADDR_WIDTH  word address to data memory
- o_wdata  out  32  lane-aligned write data
- o_we  out  1  write enable
- o_mem_type  out  4  byte-lane enables for read and write
- i_rdata  in  32  data memory read data (one cycle after address; disabled lanes read as zero)
- o_ld_valid  out  1  load result valid this cycle
- o_ld_data  out  32  aligned, extended load result

## Operation
- off = baddr[1:0]; n = 1/2/4 bytes by size; m8 = ((1<<n)-1) << off (8 bits); split = m8[7:4] != 0.
- w64 = {32'b0, i_wdata} << 8*off. The first access uses m8[3:0] and w64[31:0]. The second access uses m8[7:4] and w64[63:32].
- First access word = baddr[ADDR_WIDTH+1:2]. Second access word = first + 1, modulo 2**ADDR_WIDTH, so word DEPTH-1 wraps to 0.
- FSM states:
  - IDLE: request outputs are combinational from the i_* ports.
    - i_valid & (load|store) drives the first access; o_we = i_store.
    - If split, capture second-access addr, mask, data, op, off, size and unsigned, then go to SECOND.
    - With i_valid low or no op: o_mem_type = 0, o_we = 0.
  - SECOND: drive the captured second access, then return to IDLE.
    - o_ready = 0. Upstream holds its next op, and i_* are ignored.
- o_ready = (state == IDLE).
- Load tracking uses registered bits.
  - A non-split load marks "final" for the next cycle.
  - A split load marks "lo" for the next cycle, then "final" the cycle after.
  - The lo word is captured into rlo on the cycle after the first access.
- Load result, in the cycle i_rdata holds the final word:
  - r64 = split ? {i_rdata, rlo} : {32'b0, i_rdata}.
  - v = r64 >> 8*off; take n bytes.
  - Sign-extend from bit 8n-1 unless unsigned.
- Bytes never split. Halfwords split only at off=3. Words split at off != 0.
- A store has no load result; o_ld_valid stays 0.

## Timing
- Reset (async, i_rst_n low): state = IDLE, all pending/capture registers = 0. While reset is asserted, o_we = 0, o_mem_type = 0, o_ld_valid = 0, o_ld_data = 0, o_ready = 1, o_addr = 0, o_wdata = 0.
- Aligned op accepted in cycle T: the memory is written or read at the edge ending T. The load result appears with o_ld_valid = 1 combinationally in T+1.
- Split op accepted in T: the first access is at the edge ending T and the second at the edge ending T+1. o_ready = 0 during T+1, and the next op may be presented in T+2. A split load result is valid in T+2.
- Back-to-back aligned ops issue every cycle, with one result per cycle and a one-cycle lag.
- A new op in T+2 may overlap a split-load result in T+2. Load tracking keeps them independent.
- Reset mid-split: the second access is abandoned. A split store whose first half was written stays half-written. A pending o_ld_valid is cleared.
- Write-first memory: a load to a word stored the previous cycle sees the new data.

## Test plan
- Aligned word store 0xDEADBEEF at baddr 0x010, then LW at 0x010 -> store: o_addr=4, o_mem_type=1111. Load: o_ld_data=0xDEADBEEF, o_ld_valid one cycle after issue.
- SB 0x80 at baddr 0x013, then LB and LBU at 0x013 -> store: o_mem_type=1000, o_wdata[31:24]=0x80. LB returns 0xFFFFFF80. LBU returns 0x00000080.
- SW 0x11223344 at baddr 0x006 (split) -> o_ready=0 in second cycle. Word 1 mask 1100 with data[31:16]=0x3344, then word 2 mask 0011 with data[15:0]=0x1122. LW at 0x006 returns 0x11223344 two cycles after issue.
- SH 0xA5B6 at baddr 0x003, then LH at 0x003 -> word 0 mask 1000, then word 1 mask 0001. LH returns 0xFFFFA5B6; LHU returns 0x0000A5B6.
- Wrap: LW at byte address 4*DEPTH-2 -> word DEPTH-1 mask 1100, then word 0 mask 0011. Result is {word0[15:0], wordLast[31:16]}.
- Assert i_rst_n low during the second cycle of a split store -> outputs are 0 immediately. After release: state IDLE, o_ready=1, only the first-half bytes are modified.

Source files
------------

// File: rtl/lsu_align.sv
// Load/store alignment unit: turns byte-addressed, sized accesses into word accesses with
// byte-lane enables, splits accesses that straddle a word boundary into two memory cycles,
// and rebuilds right-justified, extended load results from the returned lanes.
module lsu_align #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_load,
    input  logic                  i_store,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH+1:0] i_baddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_we,
    output logic [3:0]            o_mem_type,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_ld_valid,
    output logic [DATA_WIDTH-1:0] o_ld_data
);

    typedef enum logic [0:0] {StIdle, StSecond} state_e;

    state_e                r_state, w_state_nxt;

    // Captured second half of a split access
    logic [ADDR_WIDTH-1:0] r_addr2;
    logic [3:0]            r_mask2;
    logic [31:0]           r_wdata2;
    logic                  r_we2;
    logic [1:0]            r_off;
    logic [1:0]            r_size;
    logic                  r_uns;

    // Load tracking: r_lo = low word of a split load returns this cycle,
    // r_fin = final word returns this cycle and the result is produced
    logic                  r_lo;
    logic [31:0]           r_rlo;
    logic                  r_fin;
    logic                  r_fin_split;
    logic [1:0]            r_fin_off;
    logic [1:0]            r_fin_size;
    logic                  r_fin_uns;

    logic [1:0]            w_off;
    logic [3:0]            w_base;
    logic [7:0]            w_m8;
    logic [63:0]           w_w64;
    logic                  w_op;
    logic                  w_load;
    logic                  w_split;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_addr1;
    logic [63:0]           w_r64;
    logic [31:0]           w_v;
    logic                  w_fill;

    // Request decode: lane mask and shifted data spanning up to two words
    always_comb begin
        w_off = i_baddr[1:0];
        unique case (i_size)
            2'b00:   w_base = 4'b0001;
            2'b01:   w_base = 4'b0011;
            default: w_base = 4'b1111;
        endcase
        w_m8     = {4'b0000, w_base} << w_off;
        w_w64    = {32'b0, i_wdata} << {w_off, 3'b000};
        w_op     = i_valid & (i_load | i_store);
        w_load   = i_load & ~i_store;
        w_split  = w_op & (|w_m8[7:4]);
        w_accept = (r_state == StIdle) & w_op;
        w_addr1  = i_baddr[ADDR_WIDTH+1:2];
    end

    // Next state and memory request outputs; everything forced low while in reset
    always_comb begin
        w_state_nxt = r_state;
        o_addr      = '0;
        o_wdata     = '0;
        o_we        = 1'b0;
        o_mem_type  = 4'b0000;
        case (r_state)
            StIdle: begin
                if (w_op) begin
                    o_addr     = w_addr1;
                    o_wdata    = w_w64[31:0];
                    o_we       = i_store;
                    o_mem_type = w_m8[3:0];
                    if (w_split) begin
                        w_state_nxt = StSecond;
                    end
                end
            end
            StSecond: begin
                o_addr      = r_addr2;
                o_wdata     = r_wdata2;
                o_we        = r_we2;
                o_mem_type  = r_mask2;
                w_state_nxt = StIdle;
            end
        endcase
        if (!i_rst_n) begin
            o_addr     = '0;
            o_wdata    = '0;
            o_we       = 1'b0;
            o_mem_type = 4'b0000;
        end
    end

    assign o_ready = (r_state == StIdle);

    // State register and capture of the second half of a split access
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_addr2  <= '0;
            r_mask2  <= '0;
            r_wdata2 <= '0;
            r_we2    <= 1'b0;
            r_off    <= '0;
            r_size   <= '0;
            r_uns    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && w_split) begin
                r_addr2  <= w_addr1 + 1'b1;
                r_mask2  <= w_m8[7:4];
                r_wdata2 <= w_w64[63:32];
                r_we2    <= i_store;
                r_off    <= w_off;
                r_size   <= i_size;
                r_uns    <= i_unsigned;
            end
        end
    end

    // Load tracking kept separate from the request FSM so a new op can overlap a split result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lo        <= 1'b0;
            r_rlo       <= '0;
            r_fin       <= 1'b0;
            r_fin_split <= 1'b0;
            r_fin_off   <= '0;
            r_fin_size  <= '0;
            r_fin_uns   <= 1'b0;
        end else begin
            r_lo <= w_accept & w_load & w_split;
            if (r_lo) begin
                r_rlo <= i_rdata;
            end
            if (w_accept && w_load && !w_split) begin
                r_fin       <= 1'b1;
                r_fin_split <= 1'b0;
                r_fin_off   <= w_off;
                r_fin_size  <= i_size;
                r_fin_uns   <= i_unsigned;
            end else if (r_lo) begin
                r_fin       <= 1'b1;
                r_fin_split <= 1'b1;
                r_fin_off   <= r_off;
                r_fin_size  <= r_size;
                r_fin_uns   <= r_uns;
            end else begin
                r_fin <= 1'b0;
            end
        end
    end

    // Load result: join words, shift the addressed bytes down, then extend
    always_comb begin
        w_r64 = r_fin_split ? {i_rdata, r_rlo} : {32'b0, i_rdata};
        w_v   = 32'(w_r64 >> {r_fin_off, 3'b000});
        w_fill = 1'b0;
        o_ld_data = '0;
        unique case (r_fin_size)
            2'b00: begin
                w_fill    = ~r_fin_uns & w_v[7];
                o_ld_data = {{24{w_fill}}, w_v[7:0]};
            end
            2'b01: begin
                w_fill    = ~r_fin_uns & w_v[15];
                o_ld_data = {{16{w_fill}}, w_v[15:0]};
            end
            default: o_ld_data = w_v;
        endcase
        if (!r_fin) begin
            o_ld_data = '0;
        end
    end

    assign o_ld_valid = r_fin;

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed vector table, a reset-mid-split sequence and a randomized
// back-to-back stream checked against a byte-addressed memory model.
module tb_lsu_align;

    localparam int AW    = 11;
    localparam int DEPTH = 2 ** AW;
    localparam int NBYTE = 4 * DEPTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid, i_load, i_store, i_unsigned;
    logic [1:0]    i_size;
    logic [AW+1:0] i_baddr;
    logic [31:0]   i_wdata, i_rdata;
    logic          o_ready, o_we, o_ld_valid;
    logic [AW-1:0] o_addr;
    logic [31:0]   o_wdata, o_ld_data;
    logic [3:0]    o_mem_type;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_align #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_load     (i_load),
        .i_store    (i_store),
        .i_size     (i_size),
        .i_unsigned (i_unsigned),
        .i_baddr    (i_baddr),
        .i_wdata    (i_wdata),
        .o_addr     (o_addr),
        .o_wdata    (o_wdata),
        .o_we       (o_we),
        .o_mem_type (o_mem_type),
        .i_rdata    (i_rdata),
        .o_ld_valid (o_ld_valid),
        .o_ld_data  (o_ld_data)
    );

    // Write-first data memory, one-cycle read latency, disabled lanes read as zero
    logic [31:0] mem [0:DEPTH-1];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m, input logic we);
        for (int b = 0; b < 4; b++) if (we && m[b]) old[8*b +: 8] = wd[8*b +: 8];
        return old;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] w, input logic [3:0] m);
        for (int b = 0; b < 4; b++) if (!m[b]) w[8*b +: 8] = 8'h00;
        return w;
    endfunction

    always @(posedge clk) begin
        mem[o_addr] <= merge(mem[o_addr], o_wdata, o_mem_type, o_we);
        i_rdata     <= lanes(merge(mem[o_addr], o_wdata, o_mem_type, o_we), o_mem_type);
    end

    // Reference model: flat byte array, accesses wrap at the top of memory
    logic [7:0] ref_mem [0:NBYTE-1];

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_split(input logic [AW+1:0] ba, input logic [1:0] size);
        return (int'(ba[1:0]) + nbytes(size)) > 4;
    endfunction

    task automatic ref_store(input logic [AW+1:0] ba, input logic [1:0] size,
                             input logic [31:0] wd);
        for (int k = 0; k < nbytes(size); k++) ref_mem[(int'(ba) + k) % NBYTE] = wd[8*k +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [AW+1:0] ba, input logic [1:0] size,
                                             input logic uns);
        logic [31:0] v = 32'h0;
        int          n = nbytes(size);
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(int'(ba) + k) % NBYTE];
        if (!uns && n < 4 && v[8*n-1]) for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          st;
        bit          ld;
        logic [1:0]  size;
        bit          uns;
        logic [12:0] baddr;
        logic [31:0] wdata;
        logic [10:0] a1;
        logic [3:0]  m1;
        logic [31:0] wd1;
        bit          spl;
        logic [10:0] a2;
        logic [3:0]  m2;
        logic [31:0] wd2;
        logic [31:0] ld_exp;
    } vec_t;

    function automatic vec_t mkv(bit st, bit ld, logic [1:0] size, bit uns, logic [12:0] ba,
                                 logic [31:0] wd, logic [10:0] a1, logic [3:0] m1,
                                 logic [31:0] wd1, bit spl, logic [10:0] a2, logic [3:0] m2,
                                 logic [31:0] wd2, logic [31:0] ld_exp);
        vec_t v;
        v.st = st; v.ld = ld; v.size = size; v.uns = uns; v.baddr = ba; v.wdata = wd;
        v.a1 = a1; v.m1 = m1; v.wd1 = wd1; v.spl = spl; v.a2 = a2; v.m2 = m2; v.wd2 = wd2;
        v.ld_exp = ld_exp;
        return v;
    endfunction

    // Entered and left at #1 after a rising edge; issues one op and waits for its result
    task automatic run_vec(input vec_t v, input string nm);
        bit is_ld = v.ld && !v.st;
        i_valid = 1'b1; i_store = v.st; i_load = v.ld; i_size = v.size;
        i_unsigned = v.uns; i_baddr = v.baddr; i_wdata = v.wdata;
        if (v.st) ref_store(v.baddr, v.size, v.wdata);
        @(negedge clk);
        chk({nm, " ready1"}, 32'(o_ready), 32'd1);
        chk({nm, " addr1"}, 32'(o_addr), 32'(v.a1));
        chk({nm, " mask1"}, 32'(o_mem_type), 32'(v.m1));
        chk({nm, " we1"}, 32'(o_we), 32'(v.st));
        chk({nm, " wdata1"}, o_wdata, v.wd1);
        @(posedge clk); #1;
        i_valid = 1'b0; i_store = 1'b0; i_load = 1'b0; i_wdata = 32'h0;
        if (v.spl) begin
            @(negedge clk);
            chk({nm, " ready2"}, 32'(o_ready), 32'd0);
            chk({nm, " addr2"}, 32'(o_addr), 32'(v.a2));
            chk({nm, " mask2"}, 32'(o_mem_type), 32'(v.m2));
            chk({nm, " we2"}, 32'(o_we), 32'(v.st));
            chk({nm, " wdata2"}, o_wdata, v.wd2);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({nm, " ld_valid"}, 32'(o_ld_valid), 32'(is_ld));
        if (is_ld) chk({nm, " ld_data"}, o_ld_data, v.ld_exp);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          due;
        logic [31:0] exp;
    } pend_t;

    vec_t  tbl [17];
    pend_t q [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < DEPTH; w++) mem[w] = 32'h0;
        for (int b = 0; b < NBYTE; b++) ref_mem[b] = 8'h00;

        //        st ld sz uns baddr    wdata         a1    m1       wd1           spl a2   m2       wd2           ld_exp
        tbl[0]  = mkv(1, 0, 2, 0, 13'h010, 32'hDEADBEEF, 4, 4'b1111, 32'hDEADBEEF, 0, 0, 4'b0000, 32'h0, 32'h0);
        tbl[1]  = mkv(0, 1, 2, 0, 13'h010, 32'h0, 4, 4'b1111, 32'h0, 0, 0, 4'b0000, 32'h0, 32'hDEADBEEF);
        tbl[2]  = mkv(1, 0, 0, 0, 13'h013, 32'h80, 4, 4'b1000, 32'h80000000, 0, 0, 4'b0000, 32'h0, 32'h0);
        tbl[3]  = mkv(0, 1, 0, 0, 13'h013, 32'h0, 4, 4'b1000, 32'h0, 0, 0, 4'b0000, 32'h0, 32'hFFFFFF80);
        tbl[4]  = mkv(0, 1, 0, 1, 13'h013, 32'h0, 4, 4'b1000, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h00000080);
        tbl[5]  = mkv(0, 1, 1, 0, 13'h011, 32'h0, 4, 4'b0110, 32'h0, 0, 0, 4'b0000, 32'h0, 32'hFFFFADBE);
        tbl[6]  = mkv(1, 0, 2, 0, 13'h006, 32'h11223344, 1, 4'b1100, 32'h33440000, 1, 2, 4'b0011, 32'h00001122, 32'h0);
        tbl[7]  = mkv(0, 1, 2, 0, 13'h006, 32'h0, 1, 4'b1100, 32'h0, 1, 2, 4'b0011, 32'h0, 32'h11223344);
        tbl[8]  = mkv(1, 0, 1, 0, 13'h003, 32'hA5B6, 0, 4'b1000, 32'hB6000000, 1, 1, 4'b0001, 32'h000000A5, 32'h0);
        tbl[9]  = mkv(0, 1, 1, 0, 13'h003, 32'h0, 0, 4'b1000, 32'h0, 1, 1, 4'b0001, 32'h0, 32'hFFFFA5B6);
        tbl[10] = mkv(0, 1, 1, 1, 13'h003, 32'h0, 0, 4'b1000, 32'h0, 1, 1, 4'b0001, 32'h0, 32'h0000A5B6);
        tbl[11] = mkv(1, 0, 2, 0, 13'h1FFC, 32'hCAFEF00D, 2047, 4'b1111, 32'hCAFEF00D, 0, 0, 4'b0000, 32'h0, 32'h0);
        tbl[12] = mkv(1, 0, 1, 0, 13'h000, 32'h1357, 0, 4'b0011, 32'h00001357, 0, 0, 4'b0000, 32'h0, 32'h0);
        tbl[13] = mkv(0, 1, 2, 0, 13'h1FFE, 32'h0, 2047, 4'b1100, 32'h0, 1, 0, 4'b0011, 32'h0, 32'h1357CAFE);
        tbl[14] = mkv(1, 1, 0, 0, 13'h020, 32'hAB, 8, 4'b0001, 32'h000000AB, 0, 0, 4'b0000, 32'h0, 32'h0);
        tbl[15] = mkv(0, 1, 0, 1, 13'h020, 32'h0, 8, 4'b0001, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h000000AB);
        tbl[16] = mkv(0, 1, 3, 0, 13'h010, 32'h0, 4, 4'b1111, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h80ADBEEF);

        // Reset with an op presented: request outputs must stay quiet
        rst_n = 1'b1;
        i_valid = 1'b1; i_store = 1'b1; i_load = 1'b0; i_size = 2'b10; i_unsigned = 1'b0;
        i_baddr = 13'h010; i_wdata = 32'hFFFFFFFF;
        #1 rst_n = 1'b0;
        #10;
        chk("rst ready", 32'(o_ready), 32'd1);
        chk("rst we", 32'(o_we), 32'd0);
        chk("rst mask", 32'(o_mem_type), 32'd0);
        chk("rst addr", 32'(o_addr), 32'd0);
        chk("rst wdata", o_wdata, 32'h0);
        chk("rst ld_valid", 32'(o_ld_valid), 32'd0);
        chk("rst ld_data", o_ld_data, 32'h0);
        i_valid = 1'b0; i_store = 1'b0; i_wdata = 32'h0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // Reset during the second cycle of a split store: only the first half lands
        i_valid = 1'b1; i_store = 1'b1; i_load = 1'b0; i_size = 2'b10; i_unsigned = 1'b0;
        i_baddr = 13'h00A; i_wdata = 32'h55667788;
        @(posedge clk); #1;
        i_valid = 1'b0; i_store = 1'b0; i_wdata = 32'h0;
        chk("rsplit ready", 32'(o_ready), 32'd0);
        chk("rsplit mask2", 32'(o_mem_type), 32'b0011);
        rst_n = 1'b0;
        #1;
        chk("rsplit we", 32'(o_we), 32'd0);
        chk("rsplit mask", 32'(o_mem_type), 32'd0);
        chk("rsplit addr", 32'(o_addr), 32'd0);
        chk("rsplit ready_rst", 32'(o_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rsplit ready_post", 32'(o_ready), 32'd1);
        ref_mem[10] = 8'h88;
        ref_mem[11] = 8'h77;
        run_vec(mkv(0, 1, 2, 0, 13'h008, 32'h0, 2, 4'b1111, 32'h0, 0, 0, 4'b0000, 32'h0,
                    32'h77881122), "rsplit lo");
        run_vec(mkv(0, 1, 2, 0, 13'h00C, 32'h0, 3, 4'b1111, 32'h0, 0, 0, 4'b0000, 32'h0,
                    32'h00000000), "rsplit hi");

        // Randomized back-to-back stream against the byte model
        for (int i = 0; i < 600; i++) begin
            if (o_ready) begin
                logic [12:0] r = 13'($urandom);
                i_valid    = ($urandom_range(0, 3) != 0);
                i_store    = ($urandom_range(0, 2) == 0);
                i_load     = ($urandom_range(0, 4) != 0);
                i_size     = 2'($urandom_range(0, 3));
                i_unsigned = 1'($urandom);
                i_baddr    = $urandom_range(0, 1) ? (r | 13'h1FC0) : (r & 13'h003F);
                i_wdata    = $urandom;
                if (i_valid && i_store) begin
                    ref_store(i_baddr, i_size, i_wdata);
                end else if (i_valid && i_load) begin
                    q.push_back('{due: i + (is_split(i_baddr, i_size) ? 2 : 1),
                                  exp: ref_load(i_baddr, i_size, i_unsigned)});
                end
            end else begin
                // Ignored during the second half of a split
                i_valid = 1'($urandom); i_store = 1'($urandom); i_load = 1'($urandom);
                i_baddr = 13'($urandom); i_wdata = $urandom; i_size = 2'($urandom);
            end
            @(negedge clk);
            if (o_ld_valid || (q.size() > 0 && q[0].due == i)) begin
                if (q.size() > 0 && q[0].due == i) begin
                    chk($sformatf("rnd c%0d ld_valid", i), 32'(o_ld_valid), 32'd1);
                    chk($sformatf("rnd c%0d ld_data", i), o_ld_data, q[0].exp);
                    void'(q.pop_front());
                end else begin
                    chk($sformatf("rnd c%0d spurious ld_valid", i), 32'(o_ld_valid), 32'd0);
                end
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_store = 1'b0; i_load = 1'b0;
        repeat (3) @(posedge clk);
        chk("rnd drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
